// File: rtl/pipeline_pkg.sv
// Shared definitions for the 2-wide bundle pipeline: slot/bundle layout,
// opcodes and the NOP encoding used to fill empty pipeline slots.
package pipeline_pkg;

    localparam int SLOT_W   = 32;
    localparam int BUNDLE_W = 2 * SLOT_W;

    // Bundle layout: upper slot in [63:32], lower slot in [31:0].
    localparam int UPPER_MSB = 63;
    localparam int UPPER_LSB = 32;
    localparam int LOWER_MSB = 31;
    localparam int LOWER_LSB = 0;

    // Opcode field inside a slot.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 29;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

    localparam logic [OPC_W-1:0] OP_ALU    = 3'b000;
    localparam logic [OPC_W-1:0] OP_ALUI   = 3'b001;
    localparam logic [OPC_W-1:0] OP_LOAD   = 3'b010;
    localparam logic [OPC_W-1:0] OP_STORE  = 3'b011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 3'b100;
    localparam logic [OPC_W-1:0] OP_JUMP   = 3'b101;
    localparam logic [OPC_W-1:0] OP_SYS    = 3'b110;
    localparam logic [OPC_W-1:0] OP_NOP    = 3'b111;

    localparam logic [SLOT_W-1:0]   NOP_SLOT   = {OP_NOP, 29'b0};
    localparam logic [BUNDLE_W-1:0] NOP_BUNDLE = {NOP_SLOT, NOP_SLOT};

    typedef struct packed {
        logic [SLOT_W-1:0] upper;
        logic [SLOT_W-1:0] lower;
    } bundle_t;

    function automatic logic [OPC_W-1:0] slot_opcode(input logic [SLOT_W-1:0] slot);
        return slot[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage connections: instruction BRAM port, decode handshake/redirect
// and the bundle presented to decode. master = fetch, slave = core side.
interface fetch_if #(
    parameter int IMEM_AW = 15
);
    logic               interlock;
    logic               branch_flag;
    logic [31:0]        branch_pc;
    logic [IMEM_AW-1:0] imem_addr;
    logic [63:0]        imem_dout;
    logic [31:0]        pc;
    logic [63:0]        inst;
    logic [31:0]        fetch_cnt;

    modport master (
        input  interlock, branch_flag, branch_pc, imem_dout,
        output imem_addr, pc, inst, fetch_cnt
    );

    modport slave (
        output interlock, branch_flag, branch_pc, imem_dout,
        input  imem_addr, pc, inst, fetch_cnt
    );
endinterface

// File: rtl/fetch.sv
// Instruction fetch: reads one 64-bit bundle per cycle from a 1-cycle BRAM,
// parks it while decode interlocks and redirects on decode's branch_flag.
module fetch
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          IMEM_AW  = 15
) (
    input  logic   clk,
    input  logic   rst,
    fetch_if.master bus
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   out_pc_q, out_pc_d;
    logic [31:0]   hold_pc_q, hold_pc_d;
    logic [63:0]   hold_inst_q, hold_inst_d;
    logic [31:0]   cnt_q, cnt_d;

    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        out_pc_d    = out_pc_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            BOOT: begin
                // decode is held in reset with us, so any redirect is ignored
                state_d    = RUN;
                out_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + 32'd1;
            end
            RUN, HOLD: begin
                if (bus.branch_flag) begin
                    state_d     = RUN;
                    out_pc_d    = bus.branch_pc;
                    fetch_pc_d  = bus.branch_pc + 32'd1;
                    hold_pc_d   = 32'd0;
                    hold_inst_d = NOP_BUNDLE;
                end else if (bus.interlock) begin
                    // BRAM data is only valid for one cycle; capture it on stall entry
                    if (state_q == RUN) begin
                        state_d     = HOLD;
                        hold_pc_d   = out_pc_q;
                        hold_inst_d = bus.imem_dout;
                    end
                end else begin
                    state_d    = RUN;
                    out_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd1;
                    cnt_d      = cnt_q + 32'd1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            fetch_pc_q  <= RESET_PC;
            out_pc_q    <= 32'd0;
            hold_pc_q   <= 32'd0;
            hold_inst_q <= NOP_BUNDLE;
            cnt_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            out_pc_q    <= out_pc_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        bus.pc        = 32'd0;
        bus.inst      = NOP_BUNDLE;
        bus.imem_addr = fetch_pc_q[IMEM_AW-1:0];
        if (state_q != BOOT && bus.branch_flag) begin
            bus.imem_addr = bus.branch_pc[IMEM_AW-1:0];
        end
        unique case (state_q)
            RUN: begin
                bus.pc   = out_pc_q;
                bus.inst = bus.imem_dout;
            end
            HOLD: begin
                bus.pc   = hold_pc_q;
                bus.inst = hold_inst_q;
            end
            default: begin
                bus.pc   = 32'd0;
                bus.inst = NOP_BUNDLE;
            end
        endcase
    end

    assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: a BRAM model plus a bundle-stream reference
// model (presented pc advances on accept, jumps on redirect).
module tb_fetch;
    import pipeline_pkg::*;

    localparam int          AW       = 15;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_if #(.IMEM_AW(AW)) bus();

    fetch #(.RESET_PC(RESET_PC), .IMEM_AW(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    logic [63:0] mem [0:(1<<AW)-1];
    always @(posedge clk) bus.imem_dout <= mem[bus.imem_addr];

    int checks = 0;
    int errors = 0;

    // Reference model: the bundle decode currently sees and the accept count.
    logic        m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    function automatic logic [31:0] exp_pc();
        return m_boot ? 32'h0 : m_pc;
    endfunction

    function automatic logic [63:0] exp_inst();
        logic [AW-1:0] a;
        a = m_pc[AW-1:0];
        return m_boot ? NOP_BUNDLE : mem[a];
    endfunction

    function automatic logic [AW-1:0] exp_addr();
        logic [31:0] n;
        logic [31:0] r;
        r = RESET_PC;
        n = bus.branch_flag ? bus.branch_pc : m_pc + 32'd1;
        return m_boot ? r[AW-1:0] : n[AW-1:0];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic il, input logic bf, input logic [31:0] bpc);
        bus.interlock   = il;
        bus.branch_flag = bf;
        bus.branch_pc   = bpc;
        #1;
    endtask

    task automatic model_step();
        if (m_boot) begin
            m_boot = 1'b0;
            m_pc   = RESET_PC;
        end else if (bus.branch_flag) begin
            m_pc = bus.branch_pc;
        end else if (!bus.interlock) begin
            m_pc  = m_pc + 32'd1;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = RESET_PC;
        m_cnt  = 32'd0;
    endtask

    // Leaves the bench in the BOOT cycle, inputs not yet driven.
    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_to(input logic [31:0] target);
        for (int i = 0; i < 200; i++) begin
            if (!m_boot && m_pc == target) return;
            drive(1'b0, 1'b0, 32'h0);
            model_step();
            next_cycle();
        end
        checks++;
        errors++;
        $display("FAIL run_to_timeout: model pc %h never reached %h", m_pc, target);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        r = RESET_PC;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0);
        #2;
        checks++;
        if (bus.pc !== 32'h0 || bus.inst !== NOP_BUNDLE) begin
            errors++;
            $display("FAIL in_reset_out: got pc=%h inst=%h expected pc=0 inst=%h", bus.pc, bus.inst, NOP_BUNDLE);
        end
        checks++;
        if (bus.imem_addr !== r[AW-1:0] || bus.fetch_cnt !== 32'h0) begin
            errors++;
            $display("FAIL in_reset_addr_cnt: got addr=%h cnt=%h expected addr=%h cnt=0", bus.imem_addr, bus.fetch_cnt, r[AW-1:0]);
        end
        do_reset();
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'h0 || bus.inst !== NOP_BUNDLE) begin
            errors++;
            $display("FAIL boot_cycle: got pc=%h inst=%h expected pc=0 inst=%h", bus.pc, bus.inst, NOP_BUNDLE);
        end
        model_step();
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            checks++;
            if (bus.pc !== RESET_PC + 32'(i) || bus.inst !== mem[i] || bus.fetch_cnt !== 32'(i)) begin
                errors++;
                $display("FAIL seq_%0d: got pc=%h inst=%h cnt=%h expected pc=%h inst=%h cnt=%h",
                         i, bus.pc, bus.inst, bus.fetch_cnt, RESET_PC + 32'(i), mem[i], 32'(i));
            end
            model_step();
            next_cycle();
        end
    endtask

    task automatic test_interlock();
        logic [31:0] c0;
        do_reset();
        drive(1'b0, 1'b0, 32'h0);
        model_step();
        next_cycle();
        run_to(32'd5);
        c0 = m_cnt;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 32'h0);
            checks++;
            if (bus.pc !== 32'd5 || bus.inst !== mem[5] || bus.fetch_cnt !== c0) begin
                errors++;
                $display("FAIL stall_%0d: got pc=%h inst=%h cnt=%h expected pc=5 inst=%h cnt=%h",
                         k, bus.pc, bus.inst, bus.fetch_cnt, mem[5], c0);
            end
            model_step();
            next_cycle();
        end
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'd5 || bus.inst !== mem[5]) begin
            errors++;
            $display("FAIL stall_release: got pc=%h inst=%h expected pc=5 inst=%h", bus.pc, bus.inst, mem[5]);
        end
        model_step();
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'd6 || bus.inst !== mem[6] || bus.fetch_cnt !== c0 + 32'd1) begin
            errors++;
            $display("FAIL after_stall: got pc=%h inst=%h cnt=%h expected pc=6 inst=%h cnt=%h",
                     bus.pc, bus.inst, bus.fetch_cnt, mem[6], c0 + 32'd1);
        end
        model_step();
        next_cycle();
    endtask

    task automatic test_branch();
        logic [31:0] c0;
        run_to(32'd8);
        c0 = m_cnt;
        drive(1'b0, 1'b1, 32'h40);
        checks++;
        if (bus.imem_addr !== 15'h40 || bus.pc !== 32'd8) begin
            errors++;
            $display("FAIL branch_addr: got addr=%h pc=%h expected addr=040 pc=8", bus.imem_addr, bus.pc);
        end
        model_step();
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'h40 || bus.inst !== mem[32'h40] || bus.fetch_cnt !== c0) begin
            errors++;
            $display("FAIL branch_target: got pc=%h inst=%h cnt=%h expected pc=40 inst=%h cnt=%h",
                     bus.pc, bus.inst, bus.fetch_cnt, mem[32'h40], c0);
        end
        model_step();
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'h41 || bus.inst !== mem[32'h41] || bus.fetch_cnt !== c0 + 32'd1) begin
            errors++;
            $display("FAIL branch_next: got pc=%h inst=%h cnt=%h expected pc=41 inst=%h cnt=%h",
                     bus.pc, bus.inst, bus.fetch_cnt, mem[32'h41], c0 + 32'd1);
        end
        model_step();
        next_cycle();
    endtask

    task automatic test_branch_in_hold();
        logic [31:0] cur;
        cur = m_pc;
        drive(1'b1, 1'b0, 32'h0);
        model_step();
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        model_step();
        next_cycle();
        drive(1'b1, 1'b1, 32'h123);
        checks++;
        if (bus.imem_addr !== 15'h123 || bus.pc !== cur) begin
            errors++;
            $display("FAIL hold_branch_addr: got addr=%h pc=%h expected addr=123 pc=%h", bus.imem_addr, bus.pc, cur);
        end
        model_step();
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'h123 || bus.inst !== mem[32'h123]) begin
            errors++;
            $display("FAIL hold_branch_target: got pc=%h inst=%h expected pc=123 inst=%h", bus.pc, bus.inst, mem[32'h123]);
        end
        model_step();
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'h124 || bus.inst !== mem[32'h124]) begin
            errors++;
            $display("FAIL hold_branch_next: got pc=%h inst=%h expected pc=124 inst=%h", bus.pc, bus.inst, mem[32'h124]);
        end
        model_step();
        next_cycle();
    endtask

    task automatic test_wrap();
        drive(1'b0, 1'b1, 32'hFFFF_FFFF);
        model_step();
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'hFFFF_FFFF || bus.inst !== mem[(1<<AW)-1] || bus.imem_addr !== '0) begin
            errors++;
            $display("FAIL wrap_top: got pc=%h inst=%h addr=%h expected pc=ffffffff inst=%h addr=0",
                     bus.pc, bus.inst, bus.imem_addr, mem[(1<<AW)-1]);
        end
        model_step();
        next_cycle();
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'h0 || bus.inst !== mem[0]) begin
            errors++;
            $display("FAIL wrap_zero: got pc=%h inst=%h expected pc=0 inst=%h", bus.pc, bus.inst, mem[0]);
        end
        model_step();
        next_cycle();
    endtask

    task automatic test_reset_in_hold();
        logic [31:0] r;
        r = RESET_PC;
        run_to(32'd3);
        drive(1'b1, 1'b0, 32'h0);
        model_step();
        next_cycle();
        drive(1'b1, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.pc !== 32'h0 || bus.inst !== NOP_BUNDLE || bus.imem_addr !== r[AW-1:0] || bus.fetch_cnt !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got pc=%h inst=%h addr=%h cnt=%h expected pc=0 inst=%h addr=%h cnt=0",
                     bus.pc, bus.inst, bus.imem_addr, bus.fetch_cnt, NOP_BUNDLE, r[AW-1:0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (bus.pc !== 32'h0 || bus.inst !== NOP_BUNDLE) begin
            errors++;
            $display("FAIL reboot_cycle: got pc=%h inst=%h expected pc=0 inst=%h", bus.pc, bus.inst, NOP_BUNDLE);
        end
        model_step();
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            checks++;
            if (bus.pc !== RESET_PC + 32'(i) || bus.inst !== mem[i]) begin
                errors++;
                $display("FAIL reboot_seq_%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                         i, bus.pc, bus.inst, RESET_PC + 32'(i), mem[i]);
            end
            model_step();
            next_cycle();
        end
    endtask

    task automatic test_random();
        logic        il, bf;
        logic [31:0] bpc;
        for (int n = 0; n < 400; n++) begin
            il  = ($urandom_range(0, 99) < 35);
            bf  = ($urandom_range(0, 99) < 10);
            bpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            drive(il, bf, bpc);
            checks++;
            if (bus.pc !== exp_pc() || bus.inst !== exp_inst()) begin
                errors++;
                $display("FAIL rand_out_%0d: got pc=%h inst=%h expected pc=%h inst=%h",
                         n, bus.pc, bus.inst, exp_pc(), exp_inst());
            end
            checks++;
            if (bus.imem_addr !== exp_addr() || bus.fetch_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_addr_cnt_%0d: got addr=%h cnt=%h expected addr=%h cnt=%h",
                         n, bus.imem_addr, bus.fetch_cnt, exp_addr(), m_cnt);
            end
            model_step();
            next_cycle();
        end
    endtask

    initial begin
        for (int k = 0; k < (1 << AW); k++) begin
            mem[k] = 64'(k) * 64'h0101_0101_0101_0101;
        end
        model_reset();
        test_reset();
        test_interlock();
        test_branch();
        test_branch_in_hold();
        test_wrap();
        test_reset_in_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage of the 2-wide bundle pipeline; sits directly upstream of decode.
- Drives the instruction-memory BRAM (1-cycle read latency) with a bundle address, then presents {pc, 64-bit inst} to decode.
- Handles decode's interlock by parking the bundle in a hold buffer.
- Handles decode's registered branch_flag/branch_pc by redirecting and discarding the wrong-path bundle.

Parameters:
- RESET_PC, 32'h0, first bundle address fetched after reset.
- IMEM_AW, 15, instruction-memory address width in bundles; imem_addr = low IMEM_AW bits of the fetch address.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- interlock  in  1  decode cannot accept this cycle; same signal decode sees.
- branch_flag  in  1  registered redirect from decode; bundle presented this cycle is wrong-path.
- branch_pc  in  32  redirect target (bundle index).
- imem_addr  out  IMEM_AW  BRAM read address (combinational).
- imem_dout  in  64  BRAM data for the address presented on the previous cycle.
- pc  out  32  bundle address presented to decode.
- inst  out  64  bundle presented to decode; upper slot [63:32], lower slot [31:0].
- fetch_cnt  out  32  bundles accepted by decode (perf counter).

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
- Constants: NOP slot = {3'b111, 29'b0}; NOP_BUNDLE = {NOP, NOP}.
- State: fetch_pc (next address to read), out_pc (pc of bundle on imem_dout), hold_pc/hold_inst, FSM {BOOT, RUN, HOLD}.
- Reset values: state=BOOT, fetch_pc=RESET_PC, out_pc=0, hold cleared, fetch_cnt=0.
- imem_addr, combinational:
  - branch_flag=1: branch_pc[IMEM_AW-1:0].
  - otherwise: fetch_pc[IMEM_AW-1:0].
  - During reset it equals RESET_PC.
- Outputs, combinational:
  - BOOT: pc=0, inst=NOP_BUNDLE.
  - RUN: pc=out_pc, inst=imem_dout.
  - HOLD: pc=hold_pc, inst=hold_inst.
- "Accept" = state≠BOOT & ~interlock & ~branch_flag. This matches decode's capture condition exactly.
- BOOT:
  - Lasts exactly 1 cycle.
  - Next: RUN, out_pc=fetch_pc, fetch_pc+=1.
  - branch_flag is ignored here (decode is held in reset alongside).
- RUN:
  - branch_flag=1 (wins over interlock): out_pc<=branch_pc, fetch_pc<=branch_pc+1, stay RUN. The current bundle is dropped.
  - else interlock=1: hold_pc<=out_pc, hold_inst<=imem_dout, go HOLD; fetch_pc unchanged.
  - else (accept): out_pc<=fetch_pc, fetch_pc<=fetch_pc+1, fetch_cnt+=1.
- HOLD:
  - imem_addr keeps re-reading fetch_pc; repeated reads are harmless.
  - branch_flag=1: redirect as in RUN, clear hold, go RUN.
  - else interlock=1: stay; outputs stable.
  - else (accept): out_pc<=fetch_pc, fetch_pc+=1, fetch_cnt+=1, go RUN.
- Latency: redirect visible cycle N → target bundle presented at cycle N+1 (one-bundle bubble, dropped by decode). First bundle after reset is presented 1 cycle after rst deasserts.
- Arithmetic: fetch_pc/out_pc are 32-bit and wrap mod 2^32; fetch_cnt wraps mod 2^32. Upper PC bits beyond IMEM_AW are carried but do not address memory.
- Stability: pc/inst must not change while interlock=1 and branch_flag=0. A bundle is never duplicated or skipped across any interlock length.
- Reset asserted mid-operation (any state): immediate return to reset values; hold contents discarded.

Decomposition:
- Shared package (pipeline_pkg):
  - NOP slot / NOP_BUNDLE constants.
  - Opcode localparams, consumed by decode/exec.
  - Bundle field slice positions.
- FSM state typedef stays local to fetch.
- No sub-module; the BRAM is instantiated at core top level and connected via imem_addr/imem_dout.

Test Plan:
- Reset release, RESET_PC=0, imem[k]=k·0x0101…: BOOT shows NOP_BUNDLE, pc=0; then pc=0,1,2,… on consecutive cycles with matching inst; fetch_cnt increments each cycle.
- interlock high 3 cycles while pc=5 presented: pc=5/inst=imem[5] held for all 3 cycles; on release pc=6 next cycle, no duplicate or skip; fetch_cnt frozen during stall.
- branch_flag=1, branch_pc=0x40 with pc=8 presented: imem_addr=0x40 that cycle; next cycle pc=0x40, inst=imem[0x40]; then 0x41; fetch_cnt not bumped on the dropped bundle.
- branch_flag and interlock both high in HOLD: redirect wins; hold cleared; pc=branch_pc next cycle.
- fetch_pc=32'hFFFF_FFFF: next accepted pc=0; fetch_cnt wraps from 32'hFFFF_FFFF to 0.
- rst asserted asynchronously in HOLD mid-cycle: outputs immediately pc=0, inst=NOP_BUNDLE, imem_addr=RESET_PC; after release the BOOT sequence repeats.
